// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_ctrl #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t state, state_next;

    // acc: product high half / partial remainder; q: product low half / dividend-quotient
    logic [WIDTH-1:0]   acc, q, opb;
    logic [CW-1:0]      count;
    logic               op_div, sign_q, sign_r;

    logic               is_mul, is_div, is_sgn, is_mfhi, is_mflo, is_mthi, is_mtlo, mdu_any;
    logic               issue;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic               sub_ok;
    logic [WIDTH-1:0]   sub_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    // funct decode and operand magnitude for signed ops
    always_comb begin
        is_mul  = (funct == F_MULT) || (funct == F_MULTU);
        is_div  = (funct == F_DIV)  || (funct == F_DIVU);
        is_sgn  = !funct[0];
        is_mfhi = (funct == F_MFHI);
        is_mflo = (funct == F_MFLO);
        is_mthi = (funct == F_MTHI);
        is_mtlo = (funct == F_MTLO);
        mdu_any = is_mul || is_div || is_mfhi || is_mflo || is_mthi || is_mtlo;
        a_in    = (is_sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        b_in    = (is_sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // iteration step and final sign fixup; a zero divisor leaves the dividend as remainder
    always_comb begin
        mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, opb} : '0);
        rem_sh   = {acc, q[WIDTH-1]};
        sub_ok   = rem_sh >= {1'b0, opb};
        sub_res  = rem_sh[WIDTH-1:0] - opb;
        prod     = {acc, q};
        prod_fix = sign_q ? -prod : prod;
        quot_fix = sign_q ? -q : q;
        rem_fix  = sign_r ? -acc : acc;
        if (op_div) begin
            res_hi = rem_fix;
            res_lo = (opb == '0) ? DIV0_LO : quot_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next state, issue strobe, busy and stall; flush always returns to IDLE
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid && (is_mul || is_div) && !flush) begin
                    issue      = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = op_valid && mdu_any;
                if (flush)              state_next = S_IDLE;
                else if (count == LAST) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                stall      = op_valid && mdu_any;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // operand latch, iterations, HI/LO writeback, MTHI/MTLO and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            q        <= '0;
            opb      <= '0;
            count    <= '0;
            op_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (issue) begin
                acc    <= '0;
                q      <= a_in;
                opb    <= b_in;
                count  <= '0;
                op_div <= is_div;
                sign_q <= is_sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                sign_r <= is_sgn && rs_data[WIDTH-1];
            end else if (state == S_RUN) begin
                count <= count + 1'b1;
                if (op_div) begin
                    acc <= sub_ok ? sub_res : rem_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], sub_ok};
                end else begin
                    acc <= mul_sum[WIDTH:1];
                    q   <= {mul_sum[0], q[WIDTH-1:1]};
                end
            end else if (state == S_FIX && !flush) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
                if (op_div) div_zero <= (opb == '0);
            end
            if (state == S_IDLE && op_valid && !flush) begin
                if (is_mthi) hi <= rs_data;
                if (is_mtlo) lo <= rs_data;
            end
        end
    end

    // MFHI/MFLO read port, zero when no move-from is presented in IDLE
    always_comb begin
        rd_data = '0;
        if (op_valid && state == S_IDLE) begin
            if (is_mfhi)      rd_data = hi;
            else if (is_mflo) rd_data = lo;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset, op_valid, flush;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy, done, div_zero;
    logic [31:0] rd_data, hi, lo;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
    } vec_t;

    vec_t tbl[8];

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .div_zero(div_zero),
        .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // reference: architectural HI/LO/div_zero effect computed with plain arithmetic
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (f)
            F_MULT:  begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; end
            F_MULTU: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
            F_DIV: begin
                if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; m_dz = 1'b1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    m_hi = 0; m_lo = 32'h80000000; m_dz = 1'b0;
                end else begin m_lo = sa / sb; m_hi = sa % sb; m_dz = 1'b0; end
            end
            F_DIVU: begin
                if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; m_dz = 1'b1; end
                else begin m_lo = a / b; m_hi = a % b; m_dz = 1'b0; end
            end
            F_MTHI:  m_hi = a;
            F_MTLO:  m_lo = a;
            default: ;
        endcase
    endtask

    // issue a mult/div and wait (bounded) for done; ends on the done cycle
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int cyc, busy_cnt;
        bit seen;
        @(negedge clk);
        op_valid = 1'b1; funct = f; rs_data = a; rt_data = b;
        #1 chk1("issue_stall", stall, 1'b0);
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 1; busy_cnt = 0; seen = 1'b0;
        while (cyc < 45 && !seen) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        chk1("done_seen", seen, 1'b1);
        chk("latency", cyc - 1, 33);
        chk("busy_cycles", busy_cnt, 33);
        model(f, a, b);
    endtask

    task automatic mf_check(input logic [5:0] f, input logic [31:0] exp);
        op_valid = 1'b1; funct = f;
        #1 chk("mf_rd_data", rd_data, exp);
        chk1("mf_stall", stall, 1'b0);
        op_valid = 1'b0; funct = 6'd0;
    endtask

    task automatic mt_op(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        op_valid = 1'b1; funct = f; rs_data = v;
        #1 chk1("mt_stall", stall, 1'b0);
        @(negedge clk);
        op_valid = 1'b0; funct = 6'd0;
        model(f, v, 32'd0);
    endtask

    initial begin
        logic [5:0] fsel[6];
        int         cnt;
        bit         seen;
        logic [31:0] ra, rb;
        logic [5:0]  rf;

        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV;
        fsel[3] = F_DIVU; fsel[4] = F_MTHI;  fsel[5] = F_MTLO;

        tbl[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4] = '{F_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[6] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[7] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; funct = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_dz", div_zero, 1'b0);
        chk("reset_rd", rd_data, 0);
        reset = 1'b0;

        // table-driven main function
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].e_hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].e_lo);
            chk1($sformatf("tbl%0d_dz", i), div_zero, tbl[i].e_dz);
            mf_check(F_MFLO, tbl[i].e_lo);
            mf_check(F_MFHI, tbl[i].e_hi);
            #1 chk("rd_idle_zero", rd_data, 0);
            @(negedge clk);
            chk1("done_pulse", done, 1'b0);
        end

        // MFHI right behind a MULTU stalls through completion
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULTU; rs_data = 32'h00010000; rt_data = 32'h00030000;
        @(negedge clk);
        funct = F_MFHI;
        cnt = 0;
        #1;
        while (stall && cnt < 50) begin cnt++; @(negedge clk); #1; end
        chk("dep_stall_cycles", cnt, 33);
        chk1("dep_done", done, 1'b1);
        chk("dep_rd", rd_data, 32'h3);
        op_valid = 1'b0; funct = '0;
        model(F_MULTU, 32'h00010000, 32'h00030000);

        mt_op(F_MTHI, 32'h1234);
        mf_check(F_MFHI, 32'h1234);
        mt_op(F_MTLO, 32'h5678);
        mf_check(F_MFLO, 32'h5678);

        // flush in RUN
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULT; rs_data = 32'd7; rt_data = 32'd9;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk1("flush_run_idle", busy, 1'b0);
        seen = done;
        repeat (40) begin @(negedge clk); seen = seen | done; end
        chk1("flush_run_no_done", seen, 1'b0);
        chk("flush_run_hi", hi, m_hi);
        chk("flush_run_lo", lo, m_lo);
        chk1("flush_run_dz", div_zero, m_dz);

        // flush on the FIX edge wins over the write
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (32) @(negedge clk);
        chk1("fix_busy", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk1("flush_fix_done", done, 1'b0);
        chk1("flush_fix_busy", busy, 1'b0);
        chk("flush_fix_hi", hi, m_hi);
        chk("flush_fix_lo", lo, m_lo);

        // op_valid with flush in IDLE is discarded; unknown funct is ignored
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULT; flush = 1'b1; rs_data = 32'd3; rt_data = 32'd3;
        @(negedge clk);
        funct = F_MTHI; rs_data = 32'hDEAD;
        @(negedge clk);
        funct = 6'b100000;
        #1 chk1("unk_stall", stall, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        #1 chk1("discard_busy", busy, 1'b0);
        chk("discard_hi", hi, m_hi);

        // randomized ops against the reference model
        for (int i = 0; i < 20; i++) begin
            rf = fsel[$urandom_range(0, 5)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 2) == 0) rb = $urandom_range(1, 20);
            if (rf == F_MTHI || rf == F_MTLO) mt_op(rf, ra);
            else run_op(rf, ra, rb);
            chk($sformatf("rnd%0d_hi", i), hi, m_hi);
            chk($sformatf("rnd%0d_lo", i), lo, m_lo);
            chk1($sformatf("rnd%0d_dz", i), div_zero, m_dz);
            mf_check(F_MFHI, m_hi);
        end

        // asynchronous reset in the middle of a divide
        run_op(F_DIVU, 32'd100, 32'd0);
        @(negedge clk);
        op_valid = 1'b1; funct = F_DIV; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_hi", hi, 0);
        chk("async_lo", lo, 0);
        chk1("async_busy", busy, 1'b0);
        chk1("async_done", done, 1'b0);
        chk1("async_dz", div_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        run_op(F_MULTU, 32'd6, 32'd7);
        chk("post_reset_lo", lo, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
